// File: rtl/uart_pkg.sv
// uart_pkg: shared 8N1 constants, receiver state encoding and baud helper for the UART rx/tx pair
package uart_pkg;
  localparam int DATA_BITS = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} uart_state_e;
  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO; push_i/wdata_i write, pop_i/rdata_o/valid_o read head, full_o, count_o occupancy
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign valid_o = cnt_q != '0;
  assign full_o = cnt_q == (AW+1)'(DEPTH);
  assign do_pop = pop_i & valid_o;
  // a pop in the same cycle frees the slot a push into a full FIFO needs
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata_i;
        wr_q <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a show-ahead FIFO
//   ser_rx: serial line in; rx_data/rx_valid/rx_ready: FIFO head handshake; rx_count: occupancy
//   frame_err: pulse on bad stop bit; overrun: pulse when a good byte is dropped on a full FIFO
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 40000000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ser_rx,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          frame_err,
  output logic                          overrun
);
  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int BW = CPB > 2 ? $clog2(CPB) : 1;
  localparam logic [BW-1:0] LAST = BW'(CPB - 1);
  localparam logic [BW-1:0] MID = BW'(CPB / 2 - 1);
  uart_state_e state_q;
  logic [1:0] sync_q;
  logic [BW-1:0] baud_q;
  logic [2:0] bit_q;
  logic [DATA_BITS-1:0] sr_q;
  logic frame_err_q, overrun_q, rx, push, full;
  assign rx = sync_q[1];
  // push combinationally in the stop-sample cycle so the byte is visible on the next cycle
  assign push = state_q == STOP && baud_q == LAST && rx;
  assign frame_err = frame_err_q;
  assign overrun = overrun_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else sync_q <= {sync_q[0], ser_rx};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q <= '0;
      bit_q <= '0;
      sr_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: if (!rx) begin
          state_q <= START;
          baud_q <= '0;
        end
        START: if (baud_q == MID) begin
          baud_q <= '0;
          bit_q <= '0;
          state_q <= rx ? IDLE : DATA;
        end else baud_q <= baud_q + 1'b1;
        DATA: if (baud_q == LAST) begin
          baud_q <= '0;
          sr_q <= {rx, sr_q[DATA_BITS-1:1]};
          bit_q <= bit_q + 1'b1;
          if (bit_q == 3'(DATA_BITS - 1)) state_q <= STOP;
        end else baud_q <= baud_q + 1'b1;
        STOP: if (baud_q == LAST) begin
          baud_q <= '0;
          frame_err_q <= !rx;
          state_q <= rx ? IDLE : WAIT_HIGH;
        end else baud_q <= baud_q + 1'b1;
        WAIT_HIGH: if (rx) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  // when full, rx_valid is high, so rx_ready alone tells whether a pop makes room
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overrun_q <= 1'b0;
    else overrun_q <= push & full & ~rx_ready;
  end
  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (sr_q),
    .pop_i   (rx_ready),
    .rdata_o (rx_data),
    .valid_o (rx_valid),
    .full_o  (full),
    .count_o (rx_count)
  );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo at 16 clocks per bit
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ser_rx = 1'b1;
  logic rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, overrun;
  logic [2:0] rx_count;
  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int fe0, ov0;
  uart_rx_fifo #(.CLK_FREQ(160), .BAUD_RATE(10), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ser_rx    (ser_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_count  (rx_count),
    .frame_err (frame_err),
    .overrun   (overrun)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send_bit(input logic b);
    ser_rx = b;
    idle(16);
  endtask
  task automatic send(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
    ser_rx = 1'b1;
  endtask
  task automatic pop(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, 32'(rx_valid), 32'd1);
    chk({tag, "_data"}, 32'(rx_data), 32'(exp));
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
  initial begin
    idle(3);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_count", 32'(rx_count), 32'd0);
    chk("rst_data", 32'(rx_data), 32'h00);
    chk("rst_fe", 32'(frame_err), 32'd0);
    chk("rst_ov", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    idle(5);
    send(8'hA5, 1'b1);
    idle(4);
    chk("a5_count", 32'(rx_count), 32'd1);
    chk("a5_flags", 32'(fe_cnt + ov_cnt), 32'd0);
    pop("a5", 8'hA5);
    chk("a5_empty", 32'(rx_count), 32'd0);
    ov0 = ov_cnt;
    send(8'h01, 1'b1);
    send(8'h02, 1'b1);
    send(8'h03, 1'b1);
    send(8'h04, 1'b1);
    send(8'h55, 1'b1);
    idle(4);
    chk("ovr_count", 32'(rx_count), 32'd4);
    chk("ovr_pulse", 32'(ov_cnt - ov0), 32'd1);
    pop("ovr_q0", 8'h01);
    pop("ovr_q1", 8'h02);
    pop("ovr_q2", 8'h03);
    pop("ovr_q3", 8'h04);
    chk("ovr_empty", 32'(rx_count), 32'd0);
    fe0 = fe_cnt;
    send(8'h3C, 1'b0);
    ser_rx = 1'b0;
    idle(40);
    chk("fe_pulse", 32'(fe_cnt - fe0), 32'd1);
    chk("fe_nopush", 32'(rx_count), 32'd0);
    ser_rx = 1'b1;
    idle(20);
    send(8'h5A, 1'b1);
    idle(4);
    chk("fe_once", 32'(fe_cnt - fe0), 32'd1);
    chk("fe_next_count", 32'(rx_count), 32'd1);
    pop("fe_next", 8'h5A);
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    ser_rx = 1'b0;
    idle(4);
    ser_rx = 1'b1;
    idle(40);
    chk("glitch_count", 32'(rx_count), 32'd0);
    chk("glitch_flags", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    send(8'h33, 1'b1);
    send(8'h44, 1'b1);
    idle(2);
    ov0 = ov_cnt;
    fork
      send(8'h77, 1'b1);
      begin
        idle(154);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    idle(4);
    chk("pp_count", 32'(rx_count), 32'd4);
    chk("pp_no_ov", 32'(ov_cnt - ov0), 32'd0);
    pop("pp_q0", 8'h22);
    pop("pp_q1", 8'h33);
    pop("pp_q2", 8'h44);
    pop("pp_q3", 8'h77);
    chk("pp_empty", 32'(rx_count), 32'd0);
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    fork
      send(8'hF0, 1'b1);
      begin
        idle(88);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
      end
    join
    idle(10);
    chk("rstmid_count", 32'(rx_count), 32'd0);
    chk("rstmid_flags", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);
    send(8'h0F, 1'b1);
    idle(4);
    chk("rstmid_next_count", 32'(rx_count), 32'd1);
    pop("rstmid_next", 8'h0F);
    chk("rstmid_empty", 32'(rx_valid), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
